candidate_reader: RTL and testbench

Streams a stored candidate list out of a code-set RAM as a valid/ready word stream. It is the consumer end of the list that `populate_candidates` writes. After a start pulse it reads `length` words from `base_addr` upward, through a synchronous RAM with one-cycle read latency. It buffers them in a 2-entry skid FIFO so a downstream consumer (find_iso / host readback) can apply backpressure without losing words.

---
 rtl/icblbc_pkg.sv | 15 +
 rtl/candidate_reader_skid_fifo2.sv | 64 ++++++
 rtl/candidate_reader.sv | 115 +++++++++++
 tb/tb_candidate_reader.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/icblbc_pkg.sv
// Shared definitions for the candidate-list blocks: FSM state encoding and
// default code/address widths.
package icblbc_pkg;

  localparam int CODE_W = 8;
  localparam int ADDR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/candidate_reader_skid_fifo2.sv
// Two-entry FIFO. slot0 is always the head, and slot1 is the entry behind it.
// A push and a pop on the same edge keep the order and leave the occupancy
// unchanged.
module skid_fifo2 #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_valid,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] slot0_reg;
  logic [DATA_W-1:0] slot1_reg;
  logic [1:0]        count_reg;
  logic              pop_ok;
  logic              push_ok;

  // A pop needs an entry to remove. A push is accepted when there is room,
  // or when a pop on the same edge makes room.
  always_comb begin
    pop_ok  = pop && (count_reg != 2'd0);
    push_ok = push && ((count_reg != 2'd2) || pop_ok);
  end

  // Storage and occupancy update.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot0_reg <= '0;
      slot1_reg <= '0;
      count_reg <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count_reg == 2'd0) slot0_reg <= push_data;
          else                   slot1_reg <= push_data;
          count_reg <= count_reg + 2'd1;
        end
        2'b01: begin
          slot0_reg <= slot1_reg;
          count_reg <= count_reg - 2'd1;
        end
        2'b11: begin
          if (count_reg == 2'd1) begin
            slot0_reg <= push_data;
          end else begin
            slot0_reg <= slot1_reg;
            slot1_reg <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_data  = slot0_reg;
  assign head_valid = (count_reg != 2'd0);
  assign count      = count_reg;

endmodule

// File: rtl/candidate_reader.sv
// Streams `length` words from a synchronous RAM, starting at base_addr, out as
// a valid/ready stream. A two-entry skid FIFO absorbs backpressure from the
// consumer.
module candidate_reader #(
  parameter int ADDR_W = icblbc_pkg::ADDR_W,
  parameter int DATA_W = icblbc_pkg::CODE_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              complete
);

  import icblbc_pkg::*;

  localparam int CNT_W = ADDR_W + 1;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W-1:0] rd_addr_reg;
  logic [CNT_W-1:0]  length_reg;
  logic [CNT_W-1:0]  issued_reg;
  logic [CNT_W-1:0]  delivered_reg;
  logic              inflight_reg;
  logic              pop;
  logic              issue;
  logic              accept_start;
  logic [1:0]        fifo_count;
  logic [2:0]        occ_eff;

  skid_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (inflight_reg),
    .push_data  (rd_data),
    .pop        (pop),
    .head_data  (out_data),
    .head_valid (out_valid),
    .count      (fifo_count)
  );

  // Handshake, credit check and read issue decision. The occupancy seen by
  // the credit check already includes the pop on this edge, so the stream
  // can run at one word per cycle while the FIFO still cannot overflow.
  always_comb begin
    pop          = out_valid && out_ready;
    accept_start = (state_reg == ST_IDLE) && start;
    occ_eff      = {1'b0, fifo_count} + {2'b00, inflight_reg} - {2'b00, pop};
    issue        = (state_reg == ST_FETCH) && (issued_reg != length_reg) &&
                   (occ_eff < 3'd2);
  end

  // Next-state logic. An empty list goes through DRAIN, which exits at once,
  // so that complete appears one cycle later than the start edge.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = (length == '0) ? ST_DRAIN : ST_FETCH;
      ST_FETCH: if (issued_reg == length_reg) state_next = ST_DRAIN;
      ST_DRAIN: if ((delivered_reg == length_reg) || (pop && out_last))
                  state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Datapath. rd_addr is preloaded with base on start. Each issue marks the
  // current rd_addr as captured by the RAM and advances to the next address.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      base_reg      <= '0;
      rd_addr_reg   <= '0;
      length_reg    <= '0;
      issued_reg    <= '0;
      delivered_reg <= '0;
      inflight_reg  <= 1'b0;
    end else begin
      inflight_reg <= issue;
      if (accept_start) begin
        base_reg      <= base_addr;
        rd_addr_reg   <= base_addr;
        length_reg    <= {1'b0, length};
        issued_reg    <= '0;
        delivered_reg <= '0;
      end else begin
        if (issue) begin
          rd_addr_reg <= base_reg + issued_reg[ADDR_W-1:0] + ADDR_W'(1);
          issued_reg  <= issued_reg + CNT_W'(1);
        end
        if (pop) delivered_reg <= delivered_reg + CNT_W'(1);
      end
    end
  end

  assign rd_addr  = rd_addr_reg;
  assign out_last = out_valid && (delivered_reg == length_reg - CNT_W'(1));
  assign busy     = (state_reg != ST_IDLE);
  assign complete = (state_reg == ST_DONE);

endmodule

// File: tb/tb_candidate_reader.sv
// Randomized self-checking bench for candidate_reader. It uses a behavioural
// RAM, and the expected word list comes straight from RAM contents.
module tb_candidate_reader;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base_addr = 8'd0;
  logic [7:0] length = 8'd0;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_last;
  logic       busy;
  logic       complete;

  logic [7:0] mem [256];
  int checks = 0;
  int errors = 0;

  candidate_reader #(.ADDR_W(8), .DATA_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .complete  (complete)
  );

  always #5 clock = ~clock;

  // Synchronous RAM with a one-cycle read latency.
  always @(posedge clock) rd_data <= mem[rd_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {rd_addr, out_data, out_valid, out_last, busy, complete}, 32'd0);
  endtask

  // mode 0: ready always high, 1: pattern 1,0,0,1,0,1,1, 2: random ready.
  task automatic run_stream(input logic [7:0] b, input logic [7:0] l, input int mode,
                            input bit restart_mid, input int abort_at);
    int idx, c, ncomplete, first_valid, busy_cycles, valid_seen;
    bit prev_stall, r, done;
    logic [7:0] prev_data, exp_word;
    logic prev_last;
    bit pattern [7] = '{1, 0, 0, 1, 0, 1, 1};
    @(negedge clock);
    base_addr = b; length = l; start = 1'b1; out_ready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    if (l != 0) check("rd_addr_base", rd_addr, b);
    idx = 0; c = 0; ncomplete = 0; first_valid = -1; busy_cycles = 1; valid_seen = 0;
    prev_stall = 0; prev_data = 0; prev_last = 0; done = 0;
    while (!done && c < 2000) begin
      @(negedge clock);
      c++;
      if (busy) busy_cycles++;
      if (complete) ncomplete++;
      if (out_valid) begin
        valid_seen++;
        if (first_valid < 0) first_valid = c;
      end
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_data);
        check("stall_last", out_last, prev_last);
      end
      case (mode)
        0: r = 1'b1;
        1: r = pattern[(c - 1) % 7];
        default: r = ($urandom_range(0, 3) != 0);
      endcase
      out_ready = r;
      if (out_valid && r) begin
        exp_word = mem[8'(b + 8'(idx))];
        $display("word %0d base=%02h got=%02h exp=%02h last=%0b", idx, b, out_data, exp_word, out_last);
        check("word_data", out_data, exp_word);
        check("word_last", out_last, (idx == int'(l) - 1));
        idx++;
      end
      prev_stall = out_valid && !r;
      prev_data  = out_data;
      prev_last  = out_last;
      if (restart_mid && c == 3) begin
        start = 1'b1; base_addr = b + 8'd5; length = 8'd7;
      end
      if (restart_mid && c == 4) start = 1'b0;
      if (abort_at >= 0 && idx == abort_at) begin
        @(posedge clock);
        #2 reset = 1'b1;
        #1 check_reset_outputs("reset_midstream");
        @(negedge clock);
        out_ready = 1'b0;
        reset = 1'b0;
        return;
      end
      if (ncomplete > 0 && !busy) done = 1;
    end
    if (!done) check("stream_timeout", 0, 1);
    check("complete_count", ncomplete, 1);
    check("words_delivered", idx, l);
    if (l == 0) begin
      check("len0_busy_cycles", busy_cycles, 2);
      check("len0_no_valid", valid_seen, 0);
    end else if (mode == 0) begin
      check("first_valid_cycle", first_valid, 2);
      check("busy_cycles", busy_cycles, int'(l) + 3);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'h0F; mem[8'h11] = 8'h33; mem[8'h12] = 8'h55; mem[8'h13] = 8'hFF;
    mem[8'hFE] = 8'hA1; mem[8'hFF] = 8'hB2; mem[8'h00] = 8'hC3; mem[8'h01] = 8'hD4;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset_state");
    reset = 1'b0;
    @(negedge clock);
    check_reset_outputs("idle_after_reset");

    run_stream(8'h10, 8'd4, 0, 0, -1);
    run_stream(8'h10, 8'd4, 1, 0, -1);
    run_stream(8'hFE, 8'd4, 0, 0, -1);
    run_stream(8'h20, 8'd0, 0, 0, -1);
    run_stream(8'h10, 8'd4, 0, 1, -1);
    run_stream(8'h10, 8'd4, 0, 0, 2);
    run_stream(8'h10, 8'd4, 0, 0, -1);
    for (int k = 0; k < 12; k++)
      run_stream(8'($urandom), 8'($urandom_range(1, 20)), 2, 0, -1);
    run_stream(8'($urandom), 8'd255, 2, 0, -1);
    run_stream(8'($urandom), 8'd1, 0, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
